// File: rtl/mnist_ctrl_pkg.sv
// rtl/mnist_ctrl_pkg.sv - shared types and constants for the MNIST frame sequencer
//
// Purpose: frame sequencer state encoding, default network widths and the
//          settle counter width, imported by mnist_infer_ctrl and pixel_deser.
// Ports:   none (package).
package mnist_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  localparam int N_IN_DEFAULT  = 49;
  localparam int N_OUT_DEFAULT = 2;

  // Wide enough for the largest legal settle window (15).
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/pixel_deser.sv
// rtl/pixel_deser.sv - 1-bit pixel deserializer with write index and frame flags
//
// Purpose: writes accepted pixel beats into consecutive bits of a parallel
//          register (beat k -> bit k) and flags the beat that closes a frame.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_wr          accepted pixel beat this cycle
//   i_data        pixel bit of the beat
//   i_last        beat carries the end-of-frame marker
//   i_clear       zero the register and the index (result handed off)
//   o_bits        parallel frame vector
//   o_idx_nz      write index is non-zero (a frame is partially loaded)
//   o_done        this beat closes the frame (full, or early end marker)
//   o_err         this beat closes the frame with a framing error
module pixel_deser
  import mnist_ctrl_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr,
  input  logic            i_data,
  input  logic            i_last,
  input  logic            i_clear,
  output logic [N_IN-1:0] o_bits,
  output logic            o_idx_nz,
  output logic            o_done,
  output logic            o_err
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [IDX_W-1:0] r_idx;
  logic [N_IN-1:0]  r_bits;
  logic             w_at_end;

  assign w_at_end = (r_idx == IDX_W'(N_IN - 1));

  // A frame closes either when the last bit position is written or when the
  // source marks the end early. The two conditions disagreeing is the error.
  assign o_done   = i_wr & (w_at_end | i_last);
  assign o_err    = i_wr & (w_at_end ^ i_last);
  assign o_bits   = r_bits;
  assign o_idx_nz = (r_idx != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_bits <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_bits <= '0;
    end else if (i_wr) begin
      r_bits[r_idx] <= i_data;
      // The index holds on the closing beat so it never runs past N_IN-1.
      if (!o_done) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mnist_infer_ctrl.sv
// rtl/mnist_infer_ctrl.sv - one-frame-at-a-time sequencer around an MTNCL classifier
//
// Purpose: loads a serial pixel frame into the network input vector, holds it
//          for SETTLE_CYCLES, captures the network output and offers it on a
//          valid/ready result port, with a framing error flag and frame count.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_pix_valid/o_pix_ready      pixel beat handshake
//   i_pix_data, i_pix_last       pixel bit and end-of-frame marker
//   o_net_in                     network in_bits (beat k in bit k)
//   i_net_out                    network out_bits
//   o_res_valid/i_res_ready      result handshake
//   o_res_bits, o_res_err        captured network output and framing error
//   o_busy                       frame in progress
//   o_frame_cnt                  completed result handshakes (wrapping)
module mnist_infer_ctrl
  import mnist_ctrl_pkg::*;
#(
  parameter int N_IN          = N_IN_DEFAULT,
  parameter int N_OUT         = N_OUT_DEFAULT,
  parameter int SETTLE_CYCLES = 2,    // legal range 1..15
  parameter int CNT_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_valid,
  output logic             o_pix_ready,
  input  logic             i_pix_data,
  input  logic             i_pix_last,
  output logic [N_IN-1:0]  o_net_in,
  input  logic [N_OUT-1:0] i_net_out,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [N_OUT-1:0] o_res_bits,
  output logic             o_res_err,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_frame_cnt
);

  state_t              r_state;
  logic [SETTLE_W-1:0] r_settle;
  logic                r_err;
  logic                r_res_valid;
  logic [N_OUT-1:0]    r_res_bits;
  logic                r_res_err;
  logic [CNT_W-1:0]    r_frame_cnt;

  logic w_pix_ready;
  logic w_wr;
  logic w_clear;
  logic w_done;
  logic w_err;
  logic w_idx_nz;

  // Ready is a decode of the state register only (never of i_pix_valid), and
  // is gated by i_rst so it drops in the same cycle reset is asserted.
  assign w_pix_ready = (r_state == ST_LOAD) & ~i_rst;
  assign w_wr        = i_pix_valid & w_pix_ready;
  assign w_clear     = (r_state == ST_OUTPUT) & i_res_ready;

  pixel_deser #(
    .N_IN (N_IN)
  ) u_deser (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr     (w_wr),
    .i_data   (i_pix_data),
    .i_last   (i_pix_last),
    .i_clear  (w_clear),
    .o_bits   (o_net_in),
    .o_idx_nz (w_idx_nz),
    .o_done   (w_done),
    .o_err    (w_err)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_LOAD;
      r_settle    <= '0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_bits  <= '0;
      r_res_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_done) begin
            r_err    <= w_err;
            r_settle <= SETTLE_W'(1);
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // net_in is frozen here; the network output is sampled on the
          // last settle cycle so it has had the full window to resolve.
          if (r_settle == SETTLE_W'(SETTLE_CYCLES)) begin
            r_res_bits  <= i_net_out;
            r_res_err   <= r_err;
            r_res_valid <= 1'b1;
            r_state     <= ST_OUTPUT;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_state     <= ST_LOAD;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign o_pix_ready = w_pix_ready;
  assign o_res_valid = r_res_valid;
  assign o_res_bits  = r_res_bits;
  assign o_res_err   = r_res_err;
  assign o_frame_cnt = r_frame_cnt;
  assign o_busy      = (r_state != ST_LOAD) | w_idx_nz;

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// tb/tb_mnist_infer_ctrl.sv - self-checking bench for mnist_infer_ctrl
module tb_mnist_infer_ctrl;

  localparam int NI = 49;
  localparam int NO = 2;
  localparam int SC = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic          pix_data = 1'b0;
  logic          pix_last = 1'b0;
  logic          res_ready = 1'b0;
  logic          pix_ready;
  logic [NI-1:0] net_in;
  logic [NO-1:0] net_out;
  logic          res_valid;
  logic [NO-1:0] res_bits;
  logic          res_err;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  mnist_infer_ctrl #(
    .N_IN          (NI),
    .N_OUT         (NO),
    .SETTLE_CYCLES (SC),
    .CNT_W         (CW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pix_valid (pix_valid),
    .o_pix_ready (pix_ready),
    .i_pix_data  (pix_data),
    .i_pix_last  (pix_last),
    .o_net_in    (net_in),
    .i_net_out   (net_out),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_bits  (res_bits),
    .o_res_err   (res_err),
    .o_busy      (busy),
    .o_frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in network with one register of delay, so an early sample of
  // net_out would see a stale value.
  function automatic logic [NO-1:0] net_f(input logic [NI-1:0] v);
    return {($countones(v) >= 25), v[0] ^ v[NI-1]};
  endfunction

  logic [NI-1:0] net_in_q = '0;
  always @(posedge clk) net_in_q <= net_in;
  assign net_out = net_f(net_in_q);

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  logic [NI-1:0] m_bits = '0;
  int            m_idx = 0;
  bit            m_fly = 0;      // frame closed, result not yet handed off
  bit            m_rv = 0;
  bit            m_err = 0;
  bit            m_res_err = 0;
  logic [NO-1:0] m_res_bits = '0;
  int            m_wait = 0;
  int            m_cnt = 0;
  int            t_last = 0;
  int            t_rise = 0;
  bit            prev_rv = 0;
  int            n_done = 0;
  logic [NO-1:0] q_bits[$];
  bit            q_err[$];

  always @(negedge clk) begin
    cyc++;
    if (res_valid && !prev_rv) t_rise = cyc;
    prev_rv = res_valid;
    if (rst) begin
      check("rst_pix_ready", 64'(pix_ready), 64'(0));
      check("rst_net_in",    64'(net_in),    64'(0));
      check("rst_res_valid", 64'(res_valid), 64'(0));
      check("rst_res_bits",  64'(res_bits),  64'(0));
      check("rst_res_err",   64'(res_err),   64'(0));
      check("rst_busy",      64'(busy),      64'(0));
      check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
      m_bits = '0; m_idx = 0; m_fly = 0; m_rv = 0; m_err = 0;
      m_res_err = 0; m_res_bits = '0; m_wait = 0; m_cnt = 0;
    end else begin
      check("pix_ready", 64'(pix_ready), 64'(!m_fly));
      check("net_in",    64'(net_in),    64'(m_bits));
      check("res_valid", 64'(res_valid), 64'(m_rv));
      check("busy",      64'(busy),      64'(m_fly || m_idx != 0));
      check("frame_cnt", 64'(frame_cnt), 64'(m_cnt % (1 << CW)));
      if (m_rv) begin
        check("res_bits", 64'(res_bits), 64'(m_res_bits));
        check("res_err",  64'(res_err),  64'(m_res_err));
      end
      if (!m_fly) begin
        if (pix_valid) begin
          m_bits[m_idx] = pix_data;
          if (m_idx == NI - 1 || pix_last) begin
            m_fly  = 1;
            m_err  = (m_idx == NI - 1) != pix_last;
            m_wait = SC;
            t_last = cyc;
          end else begin
            m_idx++;
          end
        end
      end else if (!m_rv) begin
        m_wait--;
        if (m_wait == 0) begin
          m_rv       = 1;
          m_res_bits = net_f(m_bits);
          m_res_err  = m_err;
        end
      end else if (res_ready) begin
        q_bits.push_back(res_bits);
        q_err.push_back(res_err);
        n_done++;
        m_rv = 0; m_fly = 0; m_bits = '0; m_idx = 0; m_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rr_rand = 0;
  bit rr_fixed = 0;
  always @(posedge clk) begin
    #1;
    res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
  end

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic beat(input logic d, input logic l, input bit gaps);
    bit acc;
    int to;
    if (gaps && $urandom_range(0, 2) == 0) begin
      pix_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = l;
    to = 0;
    do begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
      to++;
    end while (!acc && to < 300);
    if (!acc) timeout_fail("beat_accept");
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic send(input logic [NI-1:0] d, input int nb, input bit gaps);
    for (int k = 0; k < nb; k++) beat(d[k], (k == nb - 1), gaps);
  endtask

  task automatic wait_result(input int prev);
    int to = 0;
    while (n_done <= prev && to < 400) begin
      @(posedge clk);
      #1;
      to++;
    end
    if (n_done <= prev) timeout_fail("wait_result");
  endtask

  task automatic wait_valid();
    int to = 0;
    while (!res_valid && to < 100) begin
      @(negedge clk);
      to++;
    end
    if (!res_valid) timeout_fail("wait_valid");
  endtask

  int exp_cnt [5] = '{1, 2, 3, 0, 1};

  initial begin
    int p;
    logic [NI-1:0] d;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rr_fixed = 1;

    // all-ones frame
    p = n_done;
    send('1, NI, 0);
    wait_result(p);
    check("ones_bits",    64'(q_bits[$]), 64'(2'b10));
    check("ones_err",     64'(q_err[$]),  64'(0));
    check("ones_latency", 64'(t_rise - t_last), 64'(3));
    check("ones_cnt",     64'(frame_cnt), 64'(1));

    // all-zero frame with gaps
    p = n_done;
    send('0, NI, 1);
    wait_result(p);
    check("zero_bits", 64'(q_bits[$]), 64'(2'b00));
    check("zero_err",  64'(q_err[$]),  64'(0));
    check("zero_cnt",  64'(frame_cnt), 64'(2));

    // short frame: end marker on beat 10
    rr_fixed = 0;
    p = n_done;
    send('1, 10, 0);
    wait_valid();
    check("short_net_in", 64'(net_in), 64'(49'h3FF));
    check("short_busy",   64'(busy),   64'(1));
    rr_fixed = 1;
    wait_result(p);
    check("short_bits", 64'(q_bits[$]), 64'(2'b01));
    check("short_err",  64'(q_err[$]),  64'(1));
    check("short_cnt",  64'(frame_cnt), 64'(3));
    rr_fixed = 0;

    // next frame starts at bit 0, then backpressure on its result
    d = {$urandom, $urandom};
    beat(1'b1, 1'b0, 0);
    check("next_bit0", 64'(net_in), 64'(1));
    for (int k = 1; k < NI; k++) beat(d[k], (k == NI - 1), 0);
    wait_valid();
    repeat (20) begin
      @(negedge clk);
      check("bp_pix_ready", 64'(pix_ready), 64'(0));
      check("bp_res_valid", 64'(res_valid), 64'(1));
    end
    rr_fixed = 1;
    @(negedge clk);
    rr_fixed = 0;
    @(negedge clk);
    check("bp_ready_after", 64'(pix_ready), 64'(1));
    check("bp_cnt_wrap",    64'(frame_cnt), 64'(0));
    @(posedge clk);
    #1;
    rr_fixed = 1;

    // reset in the middle of a frame
    d = {$urandom, $urandom};
    for (int k = 0; k < 30; k++) beat(d[k], 1'b0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // random frames, random valid gaps and random res_ready; counter wraps
    rr_rand = 1;
    for (int i = 0; i < 5; i++) begin
      p = n_done;
      d = {$urandom, $urandom};
      send(d, NI, 1);
      wait_result(p);
      check("wrap_cnt", 64'(frame_cnt), 64'(exp_cnt[i]));
    end
    rr_rand = 0;

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
